hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised data-hazard unit for the NPC pipeline: resolves per-read-port operand sources across a configurable number of forwarding stages and read ports, and keeps a per-register scoreboard of in-flight writes, so hazards from variable-latency units that have left the forwarding window are also caught. Sits beside the IDU. Drives the operand-mux selects and the IDU issue stall. Adds a deadlock watchdog and optional performance counters.

## Interface
Parameters:
- NREAD, 2, number of IDU source-register read ports
- NFWD, 3, number of forwarding stages; index 0 = youngest (EXU), NFWD-1 = oldest
- PEND_W, 2, width of each per-register pending-write counter; max outstanding = 2^PEND_W-1
- STALL_LIMIT, 1024, consecutive stall cycles that trigger the watchdog
- CW (derived), $clog2(NFWD+1), width of one choice field

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- IDU_valid  in  1  IDU holds a valid instruction
- IDU_rs  in  NREAD*5  packed source registers, port p at [5p+4:5p]
- IDU_rs_used  in  NREAD  port p actually reads its register
- IDU_rd  in  5  destination of IDU instruction
- IDU_R_Wen  in  1  IDU instruction writes rd
- IDU_fire  in  1  IDU instruction issued this cycle (IDU_valid & downstream ready & ~stall)
- FWD_valid  in  NFWD  stage i holds a valid instruction
- FWD_R_Wen  in  NFWD  stage i writes a register
- FWD_rd  in  NFWD*5  packed stage destinations
- FWD_data_ok  in  NFWD  stage i result available this cycle (0 for load still in MEM)
- WB_commit  in  1  register-file write retired this cycle
- WB_rd  in  5  retired destination
- flush  in  1  pipeline flush; clears scoreboard
- rs_choice  out  NREAD*CW  per port: 0 = register file, i+1 = forward from stage i
- stall  out  1  IDU must not issue
- watchdog_err  out  1  sticky deadlock flag
- perf_stall_cycles  out  32  stall-cycle count
- perf_fwd_hits  out  32  forwarded-operand count

## Operation
- Scoreboard: pend[1..31], PEND_W bits each; x0 never tracked, reads 0.
- Increment pend[IDU_rd] on IDU_fire & IDU_R_Wen & IDU_rd!=0.
- Decrement pend[WB_rd] on WB_commit & WB_rd!=0; saturates at 0.
- Increment and decrement of the same register in one cycle: net unchanged.
- flush: all pend cleared to 0, overriding same-cycle increments and decrements.
- Per port p, when IDU_valid & IDU_rs_used[p] & rs!=0: match[i] = FWD_valid[i] & FWD_R_Wen[i] & FWD_rd[i]==rs. Lowest matching i wins.
  - Winner with FWD_data_ok=1: choice=i+1.
  - Winner with FWD_data_ok=0: choice=i+1, port stalls.
  - No match, pend[rs]!=0: choice=0, port stalls (long-latency write outside window).
  - Otherwise: choice=0.
- For an unused port, rs=0, or IDU_valid=0: choice=0 and no stall contribution.
- stall = OR of port stalls | (IDU_valid & IDU_R_Wen & IDU_rd!=0 & pend[IDU_rd] at max).
- Watchdog: cnt increments while stall & IDU_valid; cleared by any non-stall cycle or flush; saturates at STALL_LIMIT. watchdog_err sets when cnt reaches STALL_LIMIT and clears only on reset.
- IDU_fire while stall=1 is a protocol violation. Behaviour is undefined; the bench asserts it never happens.

## Timing
- rs_choice and stall are combinational from inputs and current pend; zero latency.
- pend, watchdog counter and perf counters update at the rising edge; an issue is visible to the next cycle's lookup.
- Retire in cycle N: the register reads ready in cycle N+1. No same-cycle bypass of a WB decrement.
- Reset (rst_n=0 at the edge): pend=0, watchdog cnt=0, watchdog_err=0, perf counters=0. rs_choice=0 and stall=0 whenever inputs are idle. Reset mid-operation discards all scoreboard state.

## Configuration
- HAZARD_PERF_EN defined:
  - perf_stall_cycles increments on each stall & IDU_valid cycle.
  - perf_fwd_hits increments by the number of ports with nonzero choice on an IDU_fire cycle.
  - Both counters wrap at 2^32.
- HAZARD_PERF_EN undefined: both outputs are constant 0 and no counter flops are built.

## Test plan
- EXU (stage 0) writes x5 with data ok, and MEM writes x5; IDU reads x5 on port 0 -> rs_choice port0 = 1, stall = 0.
- MEM (stage 1) load to x7 with FWD_data_ok = 0; IDU reads x7 -> choice = 2, stall = 1. Next cycle data_ok = 1 -> stall = 0.
- Issue a write to x9, let it leave all FWD stages; IDU reads x9 -> stall = 1. WB_commit x9 in cycle N -> stall = 0 in cycle N+1.
- PEND_W = 2: three issues to x3 with no retire -> a fourth write to x3 raises stall. Same-cycle issue and retire on x3 leaves the count at 3.
- Hold a stall STALL_LIMIT cycles -> watchdog_err = 1 and remains set after flush; rst_n low one edge -> 0.
- With HAZARD_PERF_EN, two ports forwarded on one fire plus 4 stall cycles -> perf_fwd_hits = 2, perf_stall_cycles = 4. Without HAZARD_PERF_EN -> both outputs 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Data-hazard unit: per-port operand forwarding selects, a pending-write
// scoreboard, a stall watchdog, and perf counters (HAZARD_PERF_EN).
module hazard_scoreboard #(
  parameter int NREAD       = 2,
  parameter int NFWD        = 3,
  parameter int PEND_W      = 2,
  parameter int STALL_LIMIT = 1024,
  localparam int CW         = $clog2(NFWD + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                IDU_valid,
  input  logic [NREAD*5-1:0]  IDU_rs,
  input  logic [NREAD-1:0]    IDU_rs_used,
  input  logic [4:0]          IDU_rd,
  input  logic                IDU_R_Wen,
  input  logic                IDU_fire,
  input  logic [NFWD-1:0]     FWD_valid,
  input  logic [NFWD-1:0]     FWD_R_Wen,
  input  logic [NFWD*5-1:0]   FWD_rd,
  input  logic [NFWD-1:0]     FWD_data_ok,
  input  logic                WB_commit,
  input  logic [4:0]          WB_rd,
  input  logic                flush,
  output logic [NREAD*CW-1:0] rs_choice,
  output logic                stall,
  output logic                watchdog_err,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_fwd_hits
);

  localparam int WDW = $clog2(STALL_LIMIT + 1);
  localparam logic [PEND_W-1:0] PMAX = '1;
  localparam logic [WDW-1:0] WLIM = WDW'(STALL_LIMIT);

  logic [PEND_W-1:0] pend [32];
  logic [4:0]        rs_a [NREAD];
  logic [NREAD-1:0]  hit;
  logic [NREAD-1:0]  port_stall;
  logic              rd_full;
  logic [31:0]       inc;
  logic [31:0]       dec;
  logic [WDW-1:0]    wd_cnt;
  logic [WDW-1:0]    wd_next;
  logic              stall_v;

  // Per-port source select; descending scan so the youngest match wins
  always_comb begin
    rs_choice  = '0;
    port_stall = '0;
    hit        = '0;
    for (int p = 0; p < NREAD; p++) begin
      rs_a[p] = IDU_rs[5*p +: 5];
      if (IDU_valid && IDU_rs_used[p] && rs_a[p] != 5'd0) begin
        for (int i = NFWD - 1; i >= 0; i--) begin
          if (FWD_valid[i] && FWD_R_Wen[i] &&
              FWD_rd[5*i +: 5] == rs_a[p]) begin
            rs_choice[p*CW +: CW] = CW'(i + 1);
            port_stall[p]         = ~FWD_data_ok[i];
            hit[p]                = 1'b1;
          end
        end
        if (!hit[p] && pend[rs_a[p]] != '0)
          port_stall[p] = 1'b1;
      end
    end
  end

  assign rd_full = IDU_valid & IDU_R_Wen & (IDU_rd != 5'd0) &
                   (pend[IDU_rd] == PMAX);
  assign stall   = (|port_stall) | rd_full;
  assign stall_v = stall & IDU_valid;

  assign inc = (IDU_fire && IDU_R_Wen) ? (32'd1 << IDU_rd) : 32'd0;
  assign dec = WB_commit ? (32'd1 << WB_rd) : 32'd0;

  // Scoreboard: issue increments, retire decrements, flush clears
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int r = 0; r < 32; r++)
        pend[r] <= '0;
    end else begin
      pend[0] <= '0;
      for (int r = 1; r < 32; r++) begin
        if (inc[r] && !dec[r] && pend[r] != PMAX)
          pend[r] <= pend[r] + 1'b1;
        else if (dec[r] && !inc[r] && pend[r] != '0)
          pend[r] <= pend[r] - 1'b1;
      end
    end
  end

  // Next watchdog count: run on stall, saturate at the limit
  always_comb begin
    wd_next = '0;
    if (!flush && stall_v)
      wd_next = (wd_cnt == WLIM) ? wd_cnt : wd_cnt + 1'b1;
  end

  // Watchdog counter and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt       <= '0;
      watchdog_err <= 1'b0;
    end else begin
      wd_cnt <= wd_next;
      if (wd_next == WLIM)
        watchdog_err <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam int HW = $clog2(NREAD + 1);
  logic [HW-1:0] nhit;

  // Count ports sourcing a forwarded operand
  always_comb begin
    nhit = '0;
    for (int p = 0; p < NREAD; p++)
      if (rs_choice[p*CW +: CW] != '0)
        nhit = nhit + 1'b1;
  end

  // Wrapping performance counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_fwd_hits     <= '0;
    end else begin
      if (stall_v)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (IDU_fire)
        perf_fwd_hits <= perf_fwd_hits + 32'(nhit);
    end
  end
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_fwd_hits     = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: vector table, corner sequences,
// and randomized traffic against a scoreboard reference model.
module tb_hazard_scoreboard;

  localparam int NREAD = 2;
  localparam int NFWD  = 3;
  localparam int CW    = 2;
  localparam int MAXP  = 3;
  localparam int LIMIT = 1024;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IDU_valid;
  logic [9:0]  IDU_rs;
  logic [1:0]  IDU_rs_used;
  logic [4:0]  IDU_rd;
  logic        IDU_R_Wen;
  logic        IDU_fire;
  logic [2:0]  FWD_valid;
  logic [2:0]  FWD_R_Wen;
  logic [14:0] FWD_rd;
  logic [2:0]  FWD_data_ok;
  logic        WB_commit;
  logic [4:0]  WB_rd;
  logic        flush;
  logic [3:0]  rs_choice;
  logic        stall;
  logic        watchdog_err;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_fwd_hits;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .IDU_valid(IDU_valid), .IDU_rs(IDU_rs),
    .IDU_rs_used(IDU_rs_used), .IDU_rd(IDU_rd),
    .IDU_R_Wen(IDU_R_Wen), .IDU_fire(IDU_fire),
    .FWD_valid(FWD_valid), .FWD_R_Wen(FWD_R_Wen),
    .FWD_rd(FWD_rd), .FWD_data_ok(FWD_data_ok),
    .WB_commit(WB_commit), .WB_rd(WB_rd),
    .flush(flush), .rs_choice(rs_choice),
    .stall(stall), .watchdog_err(watchdog_err),
    .perf_stall_cycles(perf_stall_cycles),
    .perf_fwd_hits(perf_fwd_hits)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  int          mpend [32];
  int          mcnt;
  logic        merr;
  logic [31:0] mps;
  logic [31:0] mph;

  typedef struct {
    logic        valid;
    logic [9:0]  rs;
    logic [1:0]  used;
    logic [2:0]  fv;
    logic [2:0]  fw;
    logic [2:0]  ok;
    logic [14:0] frd;
    logic [3:0]  ch;
    logic        st;
  } vec_t;

  vec_t tbl [10];

  always @(negedge clk)
    assert (!(IDU_fire && stall))
      else $error("FAIL protocol: IDU_fire while stall");

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  task automatic idle();
    IDU_valid = 0; IDU_rs = '0; IDU_rs_used = '0;
    IDU_rd = '0; IDU_R_Wen = 0; IDU_fire = 0;
    FWD_valid = '0; FWD_R_Wen = '0; FWD_rd = '0;
    FWD_data_ok = '0; WB_commit = 0; WB_rd = '0;
    flush = 0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) mpend[r] = 0;
    mcnt = 0; merr = 0; mps = '0; mph = '0;
  endtask

  task automatic model_eval(output logic [3:0] ch,
                            output logic st, output int nz);
    ch = '0; st = 0; nz = 0;
    for (int p = 0; p < NREAD; p++) begin
      int r = int'(IDU_rs[5*p +: 5]);
      if (IDU_valid && IDU_rs_used[p] && r != 0) begin
        int w = -1;
        for (int i = 0; i < NFWD; i++)
          if (w < 0 && FWD_valid[i] && FWD_R_Wen[i] &&
              int'(FWD_rd[5*i +: 5]) == r)
            w = i;
        if (w >= 0) begin
          ch[p*CW +: CW] = 2'(w + 1);
          nz++;
          if (!FWD_data_ok[w]) st = 1;
        end else if (mpend[r] > 0) st = 1;
      end
    end
    if (IDU_valid && IDU_R_Wen && IDU_rd != 0 &&
        mpend[IDU_rd] == MAXP)
      st = 1;
  endtask

  task automatic chk_model();
    logic [3:0] ch; logic st; int nz;
    model_eval(ch, st, nz);
    chk("choice", rs_choice, ch);
    chk("stall", stall, st);
    chk("wdog", watchdog_err, merr);
    chk("perf_stall", perf_stall_cycles, PERF ? mps : 32'd0);
    chk("perf_hits", perf_fwd_hits, PERF ? mph : 32'd0);
  endtask

  task automatic adv();
    logic [3:0] ch; logic st; int nz;
    model_eval(ch, st, nz);
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      if (flush) begin
        for (int r = 0; r < 32; r++) mpend[r] = 0;
      end else begin
        for (int r = 1; r < 32; r++) begin
          bit inc = IDU_fire && IDU_R_Wen && int'(IDU_rd) == r;
          bit dec = WB_commit && int'(WB_rd) == r;
          if (inc && !dec && mpend[r] < MAXP) mpend[r]++;
          else if (dec && !inc && mpend[r] > 0) mpend[r]--;
        end
      end
      if (flush || !st) mcnt = 0;
      else if (mcnt < LIMIT) mcnt++;
      if (mcnt == LIMIT) merr = 1;
      if (st) mps = mps + 32'd1;
      if (IDU_fire) mph = mph + 32'(nz);
    end
    #1;
  endtask

  task automatic settle(); #2; endtask
  task automatic tick(); chk_model(); adv(); endtask
  task automatic cyc(); settle(); tick(); endtask

  function automatic vec_t mk(logic v, logic [9:0] rs,
      logic [1:0] u, logic [2:0] fv, logic [2:0] fw,
      logic [2:0] ok, logic [14:0] frd, logic [3:0] ch,
      logic st);
    vec_t t;
    t.valid = v; t.rs = rs; t.used = u; t.fv = fv;
    t.fw = fw; t.ok = ok; t.frd = frd; t.ch = ch; t.st = st;
    return t;
  endfunction

  initial begin
    logic [3:0] ech; logic est; int enz;
    tbl[0] = mk(0, 10'd0, 2'b00, 3'b000, 3'b000, 3'b000,
                15'd0, 4'b0000, 0);
    tbl[1] = mk(1, {5'd0, 5'd5}, 2'b01, 3'b011, 3'b011,
                3'b011, {5'd0, 5'd5, 5'd5}, 4'b0001, 0);
    tbl[2] = mk(1, {5'd0, 5'd7}, 2'b01, 3'b010, 3'b010,
                3'b000, {5'd0, 5'd7, 5'd0}, 4'b0010, 1);
    tbl[3] = mk(1, {5'd0, 5'd7}, 2'b01, 3'b010, 3'b010,
                3'b010, {5'd0, 5'd7, 5'd0}, 4'b0010, 0);
    tbl[4] = mk(1, {5'd0, 5'd7}, 2'b00, 3'b010, 3'b010,
                3'b000, {5'd0, 5'd7, 5'd0}, 4'b0000, 0);
    tbl[5] = mk(1, 10'd0, 2'b11, 3'b001, 3'b001, 3'b000,
                15'd0, 4'b0000, 0);
    tbl[6] = mk(1, {5'd12, 5'd3}, 2'b11, 3'b101, 3'b101,
                3'b101, {5'd12, 5'd0, 5'd3}, 4'b1101, 0);
    tbl[7] = mk(1, {5'd0, 5'd5}, 2'b01, 3'b001, 3'b000,
                3'b000, {5'd0, 5'd0, 5'd5}, 4'b0000, 0);
    tbl[8] = mk(0, {5'd0, 5'd7}, 2'b01, 3'b010, 3'b010,
                3'b000, {5'd0, 5'd7, 5'd0}, 4'b0000, 0);
    tbl[9] = mk(1, {5'd4, 5'd0}, 2'b10, 3'b110, 3'b110,
                3'b100, {5'd4, 5'd4, 5'd0}, 4'b1000, 1);

    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1;
    settle();
    chk("rst_choice", rs_choice, 4'd0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_wdog", watchdog_err, 1'b0);
    chk("rst_perf_s", perf_stall_cycles, 32'd0);
    chk("rst_perf_h", perf_fwd_hits, 32'd0);
    tick();

    for (int k = 0; k < 10; k++) begin
      idle();
      IDU_valid = tbl[k].valid; IDU_rs = tbl[k].rs;
      IDU_rs_used = tbl[k].used; FWD_valid = tbl[k].fv;
      FWD_R_Wen = tbl[k].fw; FWD_data_ok = tbl[k].ok;
      FWD_rd = tbl[k].frd;
      settle();
      chk($sformatf("tbl%0d_choice", k), rs_choice, tbl[k].ch);
      chk($sformatf("tbl%0d_stall", k), stall, tbl[k].st);
      tick();
    end

    idle();
    IDU_valid = 1; IDU_R_Wen = 1; IDU_rd = 5'd9; IDU_fire = 1;
    cyc();
    idle();
    repeat (3) cyc();
    IDU_valid = 1; IDU_rs = 10'd9; IDU_rs_used = 2'b01;
    settle(); chk("x9_pending", stall, 1'b1); tick();
    WB_commit = 1; WB_rd = 5'd9;
    settle(); chk("x9_wb_same", stall, 1'b1); tick();
    WB_commit = 0;
    settle();
    chk("x9_ready", stall, 1'b0);
    chk("x9_choice", rs_choice, 4'd0);
    tick();

    idle();
    repeat (3) begin
      IDU_valid = 1; IDU_R_Wen = 1; IDU_rd = 5'd3; IDU_fire = 1;
      cyc();
    end
    IDU_fire = 0;
    settle(); chk("x3_full", stall, 1'b1); tick();
    idle(); WB_commit = 1; WB_rd = 5'd3; cyc();
    IDU_valid = 1; IDU_R_Wen = 1; IDU_rd = 5'd3; IDU_fire = 1;
    settle(); chk("x3_incdec_ok", stall, 1'b0); tick();
    WB_commit = 0; IDU_fire = 0;
    settle(); chk("x3_net", stall, 1'b0); tick();
    IDU_fire = 1; cyc();
    IDU_fire = 0;
    settle(); chk("x3_full2", stall, 1'b1); tick();
    idle(); flush = 1; cyc(); idle();

    rst_n = 0; cyc(); rst_n = 1;
    IDU_valid = 1; IDU_rs = {5'd6, 5'd5}; IDU_rs_used = 2'b11;
    FWD_valid = 3'b011; FWD_R_Wen = 3'b011;
    FWD_data_ok = 3'b011; FWD_rd = {5'd0, 5'd6, 5'd5};
    IDU_fire = 1;
    settle(); chk("perf_two_ch", rs_choice, 4'b1001); tick();
    idle();
    IDU_valid = 1; IDU_rs = 10'd7; IDU_rs_used = 2'b01;
    FWD_valid = 3'b001; FWD_R_Wen = 3'b001; FWD_rd = 15'd7;
    repeat (4) cyc();
    idle();
    settle();
    chk("perf_hits_2", perf_fwd_hits, PERF ? 32'd2 : 32'd0);
    chk("perf_stall_4", perf_stall_cycles, PERF ? 32'd4 : 32'd0);
    tick();

    IDU_valid = 1; IDU_rs = 10'd7; IDU_rs_used = 2'b01;
    FWD_valid = 3'b001; FWD_R_Wen = 3'b001; FWD_rd = 15'd7;
    repeat (LIMIT - 1) cyc();
    settle(); chk("wd_pre", watchdog_err, 1'b0); tick();
    settle(); chk("wd_set", watchdog_err, 1'b1); tick();
    idle(); flush = 1; cyc(); flush = 0;
    settle(); chk("wd_flush", watchdog_err, 1'b1); tick();
    rst_n = 0; cyc(); rst_n = 1;
    settle(); chk("wd_reset", watchdog_err, 1'b0); tick();

    for (int n = 0; n < 2000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      flush = ($urandom_range(0, 49) == 0);
      IDU_valid = $urandom_range(0, 3) != 0;
      IDU_rs = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      IDU_rs_used = 2'($urandom);
      IDU_rd = 5'($urandom_range(0, 7));
      IDU_R_Wen = 1'($urandom);
      FWD_valid = 3'($urandom);
      FWD_R_Wen = 3'($urandom);
      FWD_data_ok = 3'($urandom);
      FWD_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7))};
      WB_commit = $urandom_range(0, 3) == 0;
      WB_rd = 5'($urandom_range(0, 7));
      IDU_fire = 0;
      model_eval(ech, est, enz);
      IDU_fire = IDU_valid & ~est & 1'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
